alu_op_sequencer: RTL and testbench

- Shares one 32-bit gate-level ALU (combinational, multi-gate propagation delay) between two requesters.
- Round-robin arbitration between the requesters.
- Drives the ALU command and operands from registers, waits a command-dependent settle count, captures the result and flags, then returns them on a valid/ready response channel.
- Sits between the two requesters and the ALU instance.

---
 rtl/alu_ctrl_pkg.sv | 28 ++
 rtl/alu_op_sequencer_if.sv | 67 ++++++
 rtl/rr_arbiter2.sv | 21 ++
 rtl/alu_op_sequencer.sv | 99 +++++++++
 tb/tb_alu_op_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU operation sequencer:
// command values, FSM states and the settle-class helper.
package alu_ctrl_pkg;

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  function automatic logic is_arith(
    input logic [2:0] command
  );
    return (command == CMD_ADD) ||
           (command == CMD_SUB) ||
           (command == CMD_SLT);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Requester, response and ALU-side signals of the sequencer.
// slave is the sequencer's view; master is the environment's.
interface alu_op_sequencer_if;

  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_command;
  logic [31:0] req0_operandA;
  logic [31:0] req0_operandB;

  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_command;
  logic [31:0] req1_operandA;
  logic [31:0] req1_operandB;

  logic [2:0]  alu_command;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [31:0] alu_result;
  logic        alu_carryout;
  logic        alu_zero;
  logic        alu_overflow;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_carryout;
  logic        rsp_zero;
  logic        rsp_overflow;

  modport slave (
    input  req0_valid, req0_command,
    input  req0_operandA, req0_operandB,
    output req0_ready,
    input  req1_valid, req1_command,
    input  req1_operandA, req1_operandB,
    output req1_ready,
    output alu_command,
    output alu_operandA, alu_operandB,
    input  alu_result, alu_carryout,
    input  alu_zero, alu_overflow,
    output rsp_valid, rsp_id, rsp_result,
    output rsp_carryout, rsp_zero,
    output rsp_overflow,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_command,
    output req0_operandA, req0_operandB,
    input  req0_ready,
    output req1_valid, req1_command,
    output req1_operandA, req1_operandB,
    input  req1_ready,
    input  alu_command,
    input  alu_operandA, alu_operandB,
    output alu_result, alu_carryout,
    output alu_zero, alu_overflow,
    input  rsp_valid, rsp_id, rsp_result,
    input  rsp_carryout, rsp_zero,
    input  rsp_overflow,
    output rsp_ready
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; a tie goes to the
// requester that did not win last time.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (valid == 2'b11): grant = ~last_grant;
      (valid == 2'b10): grant = 1'b1;
      default:          grant = 1'b0;
    endcase
  end

  assign grant_valid = |valid;

endmodule

// File: rtl/alu_op_sequencer.sv
// Shares one slow combinational ALU between two requesters:
// arbitrate, hold operands for a settle count, capture, respond.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_ARITH = 4,
  parameter int unsigned SETTLE_LOGIC = 2
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);

  localparam logic [3:0] ARITH_M1 =
    4'(SETTLE_ARITH - 1);
  localparam logic [3:0] LOGIC_M1 =
    4'(SETTLE_LOGIC - 1);

  state_t      state;
  logic [3:0]  count;
  logic        last_grant;
  logic        grant;
  logic        grant_valid;
  logic        accept;
  logic [2:0]  cmd;
  logic [31:0] opa;
  logic [31:0] opb;

  rr_arbiter2 u_arb (
    .valid       ({bus.req1_valid, bus.req0_valid}),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // rst_n gates ready so nothing looks accepted during reset
  assign accept = rst_n & (state == IDLE) & grant_valid;
  assign bus.req0_ready = accept & ~grant;
  assign bus.req1_ready = accept & grant;

  assign cmd = grant ? bus.req1_command
                     : bus.req0_command;
  assign opa = grant ? bus.req1_operandA
                     : bus.req0_operandA;
  assign opb = grant ? bus.req1_operandB
                     : bus.req0_operandB;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      count            <= '0;
      last_grant       <= 1'b1;
      bus.alu_command  <= '0;
      bus.alu_operandA <= '0;
      bus.alu_operandB <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= 1'b0;
      bus.rsp_result   <= '0;
      bus.rsp_carryout <= 1'b0;
      bus.rsp_zero     <= 1'b0;
      bus.rsp_overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state            <= SETTLE;
            last_grant       <= grant;
            bus.rsp_id       <= grant;
            bus.alu_command  <= cmd;
            bus.alu_operandA <= opa;
            bus.alu_operandB <= opb;
            count <= is_arith(cmd) ? ARITH_M1
                                   : LOGIC_M1;
          end
        end
        SETTLE: begin
          if (count == '0) begin
            state            <= RESP;
            bus.rsp_valid    <= 1'b1;
            bus.rsp_result   <= bus.alu_result;
            bus.rsp_carryout <= bus.alu_carryout;
            bus.rsp_zero     <= bus.alu_zero;
            bus.rsp_overflow <= bus.alu_overflow;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed + random bench for alu_op_sequencer against a
// behavioural ALU and an arbitration/latency reference model.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic last_model = 1'b1;
  logic lag1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer_if bus ();
  alu_op_sequencer_if bus2 ();

  alu_op_sequencer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  alu_op_sequencer #(.SETTLE_ARITH(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  // {carry, zero, overflow, result}
  function automatic logic [34:0] alu_ref(
    input logic [2:0] c,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    logic [31:0] r;
    logic co, ov;
    co = 1'b0;
    ov = 1'b0;
    s = '0;
    case (c)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0];
        co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {co, (r == 32'd0), ov, r};
  endfunction

  function automatic int settle_of(input logic [2:0] c);
    return (c == 3'd0 || c == 3'd1 || c == 3'd3) ? 4 : 2;
  endfunction

  // ALU models: ideal, optionally lagging inputs by 3 cycles
  logic [34:0] h1 [3];
  logic [34:0] h2 [3];
  logic [34:0] y1, y2, i1, i2;
  assign i1 = alu_ref(bus.alu_command,
                      bus.alu_operandA, bus.alu_operandB);
  assign i2 = alu_ref(bus2.alu_command,
                      bus2.alu_operandA, bus2.alu_operandB);
  always @(posedge clk) begin
    h1[2] <= h1[1]; h1[1] <= h1[0]; h1[0] <= i1;
    h2[2] <= h2[1]; h2[1] <= h2[0]; h2[0] <= i2;
  end
  assign y1 = lag1 ? h1[2] : i1;
  assign y2 = h2[2];
  assign bus.alu_carryout = y1[34];
  assign bus.alu_zero     = y1[33];
  assign bus.alu_overflow = y1[32];
  assign bus.alu_result   = y1[31:0];
  assign bus2.alu_carryout = y2[34];
  assign bus2.alu_zero     = y2[33];
  assign bus2.alu_overflow = y2[32];
  assign bus2.alu_result   = y2[31:0];

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_out();
    return {bus.req1_ready, bus.req0_ready,
            bus.alu_command, bus.alu_operandA,
            bus.alu_operandB, bus.rsp_valid, bus.rsp_id,
            bus.rsp_carryout, bus.rsp_zero,
            bus.rsp_overflow, bus.rsp_result};
  endfunction

  function automatic logic [127:0] rsp_bus();
    return {bus.rsp_valid, bus.rsp_id, bus.rsp_carryout,
            bus.rsp_zero, bus.rsp_overflow, bus.rsp_result,
            bus.alu_command, bus.alu_operandA,
            bus.alu_operandB};
  endfunction

  task automatic run_op(
    input logic v0, input logic v1,
    input logic [2:0] c0, input logic [31:0] a0,
    input logic [31:0] b0,
    input logic [2:0] c1, input logic [31:0] a1,
    input logic [31:0] b1,
    input int hold, input string tag
  );
    logic id;
    logic [34:0] exp;
    logic [2:0] ec;
    logic [127:0] snap;
    int k;
    id = (v0 && v1) ? ~last_model : v1;
    ec = id ? c1 : c0;
    exp = id ? alu_ref(c1, a1, b1) : alu_ref(c0, a0, b0);
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_command = c0;
    bus.req0_operandA = a0; bus.req0_operandB = b0;
    bus.req1_valid = v1; bus.req1_command = c1;
    bus.req1_operandA = a1; bus.req1_operandB = b1;
    #1;
    chk({tag, ".grant"},
        {bus.req1_ready, bus.req0_ready},
        id ? 2'b10 : 2'b01);
    last_model = id;
    @(negedge clk);
    if (id) bus.req1_valid = 1'b0;
    else bus.req0_valid = 1'b0;
    k = 0;
    while (!bus.rsp_valid && k < 40) begin
      chk({tag, ".busy_ready"},
          {bus.req1_ready, bus.req0_ready}, 2'b00);
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, k, settle_of(ec));
    chk({tag, ".id"}, bus.rsp_id, id);
    chk({tag, ".payload"},
        {bus.rsp_carryout, bus.rsp_zero,
         bus.rsp_overflow, bus.rsp_result}, exp);
    chk({tag, ".alu_cmd"}, bus.alu_command, ec);
    snap = rsp_bus();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold"}, rsp_bus(), snap);
      chk({tag, ".hold_ready"},
          {bus.req1_ready, bus.req0_ready}, 2'b00);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk({tag, ".rsp_drop"}, bus.rsp_valid, 1'b0);
  endtask

  logic [34:0] q [$];
  logic [34:0] e;
  logic [31:0] ra, rb;
  int n, last_acc, k;
  logic [1:0] sel;

  initial begin
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_command = '0; bus.req1_command = '0;
    bus.req0_operandA = '0; bus.req0_operandB = '0;
    bus.req1_operandA = '0; bus.req1_operandB = '0;
    bus.rsp_ready = 1'b0;
    bus2.req0_valid = 1'b0; bus2.req1_valid = 1'b0;
    bus2.req0_command = '0; bus2.req1_command = '0;
    bus2.req0_operandA = '0; bus2.req0_operandB = '0;
    bus2.req1_operandA = '0; bus2.req1_operandB = '0;
    bus2.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", all_out(), '0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst_n = 1'b1;

    // short settle on a lagging ALU captures a stale value
    @(negedge clk);
    bus2.req0_valid = 1'b1; bus2.req0_command = 3'd3;
    bus2.req0_operandA = 32'd1; bus2.req0_operandB = 32'd2;
    #1 chk("stale.ready", bus2.req0_ready, 1'b1);
    @(negedge clk);
    bus2.req0_valid = 1'b0;
    k = 0;
    while (!bus2.rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("stale.latency", k, 2);
    chk("stale.result", bus2.rsp_result, 32'd0);
    bus2.rsp_ready = 1'b1;
    @(negedge clk);
    bus2.rsp_ready = 1'b0;

    run_op(1, 0, 3'd0, 32'd1, 32'd1, 3'd0, 0, 0, 0, "add");
    run_op(1, 1, 3'd2, 32'hffffffff, 0,
           3'd2, 32'hffffffff, 0, 0, "xor_a");
    run_op(0, 1, 3'd2, 0, 0,
           3'd2, 32'hffffffff, 0, 0, "xor_b");
    run_op(1, 1, 3'd2, 32'h0f0f0f0f, 32'h1,
           3'd2, 32'h12345678, 32'h0, 0, "xor_c");
    run_op(1, 1, 3'd7, 32'h5, 32'h6,
           3'd1, 32'h0, 32'h1, 5, "sub_hold");

    lag1 = 1'b1;
    run_op(1, 0, 3'd3, 32'd1, 32'd2, 0, 0, 0, 0, "slt_lag");
    lag1 = 1'b0;

    // streaming NOR with the consumer always ready
    bus.rsp_ready = 1'b1;
    n = 0; last_acc = -1;
    @(negedge clk);
    ra = $urandom; rb = $urandom;
    bus.req0_valid = 1'b1; bus.req0_command = 3'd6;
    bus.req0_operandA = ra; bus.req0_operandB = rb;
    for (int t = 0; t < 100 && n < 6; t++) begin
      #1;
      if (bus.rsp_valid) begin
        e = q.pop_front();
        chk("stream.payload",
            {bus.rsp_carryout, bus.rsp_zero,
             bus.rsp_overflow, bus.rsp_result}, e);
      end
      if (bus.req0_ready) begin
        q.push_back(alu_ref(3'd6, ra, rb));
        if (last_acc >= 0)
          chk("stream.interval", cyc - last_acc, 4);
        last_acc = cyc;
        n++;
      end
      @(negedge clk);
      if (last_acc == cyc - 1) begin
        ra = $urandom; rb = $urandom;
        bus.req0_operandA = ra; bus.req0_operandB = rb;
      end
    end
    bus.req0_valid = 1'b0;
    chk("stream.count", n, 6);
    for (int t = 0; t < 20 && q.size() > 0; t++) begin
      #1;
      if (bus.rsp_valid) begin
        e = q.pop_front();
        chk("stream.tail",
            {bus.rsp_carryout, bus.rsp_zero,
             bus.rsp_overflow, bus.rsp_result}, e);
      end
      @(negedge clk);
    end
    chk("stream.drained", q.size(), 0);
    bus.rsp_ready = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      sel = 2'($urandom_range(1, 3));
      run_op(sel[0], sel[1],
             3'($urandom), $urandom, $urandom,
             3'($urandom), $urandom, $urandom,
             $urandom_range(0, 3), "rand");
    end

    // async reset in the middle of an ADD
    run_op(1, 0, 3'd4, 32'h3, 32'h5, 0, 0, 0, 0, "pre_rst");
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_command = 3'd0;
    bus.req0_operandA = 32'd5; bus.req0_operandB = 32'd7;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("rst_async", all_out(), '0);
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst_n = 1'b1;
    last_model = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", bus.rsp_valid, 1'b0);
    end
    run_op(1, 1, 3'd0, 32'd9, 32'd1,
           3'd0, 32'd2, 32'd3, 0, "post_rst_tie");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
